// File: rtl/obstacle_spawner_pkg.sv
// Shared game definitions: spawner state encoding, lane geometry, screen
// height and the lane-seed LFSR polynomial (x^9 + x^5 + 1).
package obstacle_spawner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GAP = 3'd1,
    ST_LOAD     = 3'd2,
    ST_RUN      = 3'd3,
    ST_HALT     = 3'd4
  } spawnState_t;

  // Lane X positions; a lane seed below LANE_SPLIT selects the left lane.
  localparam logic [8:0] LANE_LEFT_X   = 9'd225;
  localparam logic [8:0] LANE_RIGHT_X  = 9'd330;
  localparam logic [8:0] LANE_SPLIT    = 9'd256;
  localparam logic [9:0] SCREEN_HEIGHT = 10'd480;

  // Feedback taps for x^9 + x^5 + 1 (bit 8 and bit 4 of the register).
  localparam int LFSR_TAP_HI = 8;
  localparam int LFSR_TAP_LO = 4;

  // One Fibonacci shift: feedback enters at bit 0.
  function automatic logic [8:0] lfsrNext(input logic [8:0] value);
    return {value[7:0], value[LFSR_TAP_HI] ^ value[LFSR_TAP_LO]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [8:0] lfsrSafeSeed(input logic [8:0] seed);
    return (seed == 9'd0) ? 9'h001 : seed;
  endfunction

endpackage

// File: rtl/obstacle_spawner_lfsr9.sv
// Free-running 9-bit maximal-length LFSR (period 511, never zero).
module lfsr9
  import obstacle_spawner_pkg::*;
#(
  parameter logic [8:0] SEED = 9'h1A5
) (
  input  logic       iClk,
  input  logic       iReset,
  output logic [8:0] oValue
);

  localparam logic [8:0] SAFE_SEED = lfsrSafeSeed(SEED);

  // Shift every clock; reset reloads the (non-zero) seed.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oValue <= SAFE_SEED;
    end else begin
      oValue <= lfsrNext(oValue);
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle command source: waits a gap, loads the car at a random lane,
// paces scroll steps from the frame tick, respawns at the bottom and halts
// on collision. oEnable/oSuma/oSalto are single-cycle, mutually exclusive
// pulses with no back-pressure: the car register must act on each one in
// the cycle it is high. The FSM state is held in `state` (spawnState_t).
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter logic [8:0] Y_START    = 9'd0,
  parameter logic [8:0] Y_LIMIT    = 9'd470,
  parameter logic [8:0] Y_STEP     = 9'd2,
  parameter logic [3:0] FRAME_DIV  = 4'd2,
  parameter logic [5:0] GAP_FRAMES = 6'd30,
  parameter logic [8:0] LFSR_SEED  = 9'h1A5
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iFrameTick,
  input  logic       iCollision,
  output logic [8:0] oPosicionX,
  output logic [8:0] oPosicionY,
  output logic       oEnable,
  output logic       oSuma,
  output logic       oSalto,
  output logic       oActive,
  output logic [7:0] oScore
);

  localparam logic [8:0] SAFE_SEED = lfsrSafeSeed(LFSR_SEED);

  spawnState_t state;
  logic [8:0]  lfsrValue;
  logic [9:0]  trackedY;
  logic [3:0]  frameCnt;
  logic [5:0]  gapCnt;

  lfsr9 #(.SEED(LFSR_SEED)) uLfsr (
    .iClk   (iClk),
    .iReset (iReset),
    .oValue (lfsrValue)
  );

  // Spawner FSM with its counters, score and registered command outputs.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= ST_IDLE;
      trackedY   <= 10'd0;
      frameCnt   <= 4'd0;
      gapCnt     <= 6'd0;
      oPosicionX <= SAFE_SEED;
      oPosicionY <= Y_START;
      oEnable    <= 1'b0;
      oSuma      <= 1'b0;
      oSalto     <= 1'b0;
      oActive    <= 1'b0;
      oScore     <= 8'd0;
    end else begin
      oEnable    <= 1'b0;
      oSuma      <= 1'b0;
      oSalto     <= 1'b0;
      oPosicionY <= Y_START;
      // Freeze the lane seed while a load/respawn pulse is on the bus.
      if (!(oEnable || oSalto)) begin
        oPosicionX <= lfsrValue;
      end

      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state   <= ST_WAIT_GAP;
            oActive <= 1'b1;
            oScore  <= 8'd0;
            gapCnt  <= 6'd0;
          end
        end

        ST_WAIT_GAP: begin
          if (iCollision) begin
            state   <= ST_HALT;
            oActive <= 1'b0;
          end else if (iFrameTick) begin
            if (gapCnt == GAP_FRAMES - 6'd1) begin
              gapCnt  <= 6'd0;
              state   <= ST_LOAD;
              oEnable <= 1'b1;
            end else begin
              gapCnt <= gapCnt + 6'd1;
            end
          end
        end

        ST_LOAD: begin
          // Frame ticks arriving in this cycle are intentionally dropped.
          if (iCollision) begin
            state   <= ST_HALT;
            oActive <= 1'b0;
          end else begin
            trackedY <= {1'b0, Y_START};
            frameCnt <= 4'd0;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (iCollision) begin
            state   <= ST_HALT;
            oActive <= 1'b0;
          end else if (trackedY >= {1'b0, Y_LIMIT}) begin
            // Bottom reached on the previous step: respawn and count it.
            oSalto   <= 1'b1;
            trackedY <= 10'd0;
            gapCnt   <= 6'd0;
            state    <= ST_WAIT_GAP;
            if (oScore != 8'hFF) begin
              oScore <= oScore + 8'd1;
            end
          end else if (iFrameTick) begin
            if (frameCnt == FRAME_DIV - 4'd1) begin
              frameCnt <= 4'd0;
              trackedY <= trackedY + {1'b0, Y_STEP};
              oSuma    <= 1'b1;
            end else begin
              frameCnt <= frameCnt + 4'd1;
            end
          end
        end

        ST_HALT: begin
          if (iStart) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          oActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: load timing, scrolling and respawn,
// collision halt, restart, mid-run reset and LFSR statistics.
module tb_obstacle_spawner;

  logic       iClk;
  logic       iReset;
  logic       iStart;
  logic       iFrameTick;
  logic       iCollision;
  logic [8:0] oPosicionX;
  logic [8:0] oPosicionY;
  logic       oEnable;
  logic       oSuma;
  logic       oSalto;
  logic       oActive;
  logic [7:0] oScore;

  localparam logic [1:0] P_ENABLE = 2'd1;
  localparam logic [1:0] P_SUMA   = 2'd2;
  localparam logic [1:0] P_SALTO  = 2'd3;

  int checks;
  int failures;

  // Expected pulse sequence, pushed when the triggering stimulus is driven.
  logic [1:0] exp_q[$];

  logic [1:0] monCode;
  logic [1:0] monExp;
  logic [8:0] heldX;
  logic [8:0] lfsrSamples[0:511];

  obstacle_spawner dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iStart     (iStart),
    .iFrameTick (iFrameTick),
    .iCollision (iCollision),
    .oPosicionX (oPosicionX),
    .oPosicionY (oPosicionY),
    .oEnable    (oEnable),
    .oSuma      (oSuma),
    .oSalto     (oSalto),
    .oActive    (oActive),
    .oScore     (oScore)
  );

  // Clock and reset-time defaults.
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic clk1();
    @(posedge iClk);
    #1;
  endtask

  // Drive a frame tick into exactly one edge.
  task automatic frameEdge();
    iFrameTick = 1'b1;
    clk1();
    iFrameTick = 1'b0;
  endtask

  // Wait out a full gap; the final tick must raise oEnable.
  task automatic runGap(input string tag);
    for (int i = 0; i < 29; i++) begin
      frameEdge();
      clk1();
    end
    exp_q.push_back(P_ENABLE);
    frameEdge();
    check({tag, "_enable"}, {15'd0, oEnable}, 16'd1);
  endtask

  // Pulse scoreboard: every observed pulse must match the next expected one.
  always @(negedge iClk) begin
    if (!iReset && (oEnable || oSuma || oSalto)) begin
      check("pulse_onehot", 16'($countones({oEnable, oSuma, oSalto})), 16'd1);
      monCode = oEnable ? P_ENABLE : (oSuma ? P_SUMA : P_SALTO);
      monExp  = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
      check("pulse_seq", {14'd0, monCode}, {14'd0, monExp});
    end
  end

  initial begin
    int lowCnt;
    int highCnt;
    int zeroCnt;
    int earlyRepeat;
    checks      = 0;
    failures    = 0;
    iReset      = 1'b1;
    iStart      = 1'b0;
    iFrameTick  = 1'b0;
    iCollision  = 1'b0;
    clk1();
    clk1();

    // Reset values.
    check("rst_x", {7'd0, oPosicionX}, 16'h01A5);
    check("rst_y", {7'd0, oPosicionY}, 16'd0);
    check("rst_pulses", {13'd0, oEnable, oSuma, oSalto}, 16'd0);
    check("rst_active", {15'd0, oActive}, 16'd0);
    check("rst_score", {8'd0, oScore}, 16'd0);
    iReset = 1'b0;
    clk1();
    check("lfsr_first", {7'd0, oPosicionX}, 16'h01A5);
    clk1();
    check("lfsr_second", {7'd0, oPosicionX}, 16'h014B);

    // 1: start, 30 ticks, single load pulse with stable lane seed.
    iStart = 1'b1;
    clk1();
    iStart = 1'b0;
    check("start_active", {15'd0, oActive}, 16'd1);
    runGap("load1");
    check("load1_y", {7'd0, oPosicionY}, 16'd0);
    check("load1_x_nonzero", {15'd0, (oPosicionX != 9'd0)}, 16'd1);
    heldX = oPosicionX;
    clk1();
    check("load1_width", {15'd0, oEnable}, 16'd0);
    check("load1_x_held", {7'd0, oPosicionX}, {7'd0, heldX});

    // 2: 235 steps of 2 ticks each, then one respawn pulse.
    for (int s = 1; s <= 235; s++) begin
      frameEdge();
      check("run_no_step", {15'd0, oSuma}, 16'd0);
      clk1();
      exp_q.push_back(P_SUMA);
      frameEdge();
      check("run_step", {15'd0, oSuma}, 16'd1);
      if (s == 235) begin
        exp_q.push_back(P_SALTO);
      end
      clk1();
    end
    check("salto_pulse", {15'd0, oSalto}, 16'd1);
    check("salto_score", {8'd0, oScore}, 16'd1);
    check("salto_active", {15'd0, oActive}, 16'd1);
    heldX = oPosicionX;
    clk1();
    check("salto_width", {15'd0, oSalto}, 16'd0);
    check("salto_x_held", {7'd0, oPosicionX}, {7'd0, heldX});

    // 3: collision on the step tick suppresses the step and halts.
    runGap("load2");
    clk1();
    frameEdge();
    clk1();
    iCollision = 1'b1;
    frameEdge();
    iCollision = 1'b0;
    check("coll_no_step", {15'd0, oSuma}, 16'd0);
    check("coll_active", {15'd0, oActive}, 16'd0);
    frameEdge();
    frameEdge();
    check("halt_active", {15'd0, oActive}, 16'd0);

    // 4: HALT -> IDLE keeps the score; the next start clears it.
    check("halt_score", {8'd0, oScore}, 16'd1);
    iStart = 1'b1;
    clk1();
    iStart = 1'b0;
    check("idle_active", {15'd0, oActive}, 16'd0);
    check("idle_score", {8'd0, oScore}, 16'd1);
    clk1();
    iStart = 1'b1;
    clk1();
    iStart = 1'b0;
    check("restart_active", {15'd0, oActive}, 16'd1);
    check("restart_score", {8'd0, oScore}, 16'd0);
    runGap("load3");
    clk1();

    // 5: reset in RUN, coinciding with what would be a step tick.
    frameEdge();
    clk1();
    iReset = 1'b1;
    frameEdge();
    check("midrst_x", {7'd0, oPosicionX}, 16'h01A5);
    check("midrst_y", {7'd0, oPosicionY}, 16'd0);
    check("midrst_pulses", {13'd0, oEnable, oSuma, oSalto}, 16'd0);
    check("midrst_active", {15'd0, oActive}, 16'd0);
    check("midrst_score", {8'd0, oScore}, 16'd0);
    iReset = 1'b0;
    clk1();
    check("midrst_idle", {15'd0, oActive}, 16'd0);

    // 6: free-running LFSR observed through oPosicionX in IDLE.
    lfsrSamples[0] = oPosicionX;
    for (int i = 1; i < 512; i++) begin
      clk1();
      lfsrSamples[i] = oPosicionX;
    end
    lowCnt = 0;
    highCnt = 0;
    zeroCnt = 0;
    earlyRepeat = 0;
    for (int i = 0; i < 511; i++) begin
      if (lfsrSamples[i] == 9'd0) zeroCnt++;
      if (lfsrSamples[i] < 9'd256) lowCnt++;
      else highCnt++;
      if (i > 0 && lfsrSamples[i] == lfsrSamples[0]) earlyRepeat++;
    end
    check("lfsr_no_zero", 16'(zeroCnt), 16'd0);
    check("lfsr_period", {7'd0, lfsrSamples[511]}, {7'd0, lfsrSamples[0]});
    check("lfsr_no_early_repeat", 16'(earlyRepeat), 16'd0);
    check("lfsr_low_lane", {15'd0, (lowCnt > 102)}, 16'd1);
    check("lfsr_high_lane", {15'd0, (highCnt > 102)}, 16'd1);

    check("pulses_outstanding", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
